te_block_serializer: RTL and testbench

- Sits between multiple_retirement and the single-port trace encoder input.
- Each cycle it accepts up to N parallel trace blocks and buffers them in a multi-write, single-read FIFO.
- It presents the blocks one per cycle, in program order, to the encoder through a valid/ready handshake.
- Overflow is detected and flagged; the commit stage is never stalled.

---
 rtl/te_block_serializer_pkg.sv | 21 ++
 rtl/te_block_serializer_if.sv | 43 ++++
 rtl/te_block_serializer_mw_fifo.sv | 56 +++++
 rtl/te_block_serializer.sv | 140 ++++++++++++++
 tb/tb_te_block_serializer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/te_block_serializer_pkg.sv
// Shared types for the trace-block serializer: field widths and the packed trace block.
// Optional statistics outputs are enabled by defining TE_SERIALIZER_STATS_EN.
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 8;
    localparam int ITYPE_LEN   = 4;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } te_block_t;

endpackage

// File: rtl/te_block_serializer_if.sv
// Block bus between the retirement stage, the serializer and the trace encoder.
// slave is the serializer side, master is the producer/consumer side.
interface te_block_serializer_if
    import mure_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 8
);
    logic [N-1:0]             valid_i;
    logic [N*IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0]             ilastsize_i;
    logic [N*ITYPE_LEN-1:0]   itype_i;
    logic [N*CAUSE_LEN-1:0]   cause_i;
    logic [N*XLEN-1:0]        tval_i;
    logic [N*PRIV_LEN-1:0]    priv_i;
    logic [N*XLEN-1:0]        iaddr_i;
    logic                     ready_i;

    logic                     valid_o;
    logic [IRETIRE_LEN-1:0]   iretire_o;
    logic                     ilastsize_o;
    logic [ITYPE_LEN-1:0]     itype_o;
    logic [CAUSE_LEN-1:0]     cause_o;
    logic [XLEN-1:0]          tval_o;
    logic [PRIV_LEN-1:0]      priv_o;
    logic [XLEN-1:0]          iaddr_o;
    logic                     almost_full_o;
    logic                     overflow_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport slave (
        input  valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
        output valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
               almost_full_o, overflow_o, count_o
    );

    modport master (
        output valid_i, iretire_i, ilastsize_i, itype_i, cause_i, tval_i, priv_i, iaddr_i, ready_i,
        input  valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o, priv_o, iaddr_o,
               almost_full_o, overflow_o, count_o
    );

endinterface

// File: rtl/te_block_serializer_mw_fifo.sv
// N-write, 1-read circular buffer; the caller writes wr_cnt_i entries from slot 0 upward.
// Full/empty come from the occupancy count, so pointers simply wrap modulo DEPTH.
module te_mw_fifo #(
    parameter int  N     = 2,
    parameter int  DEPTH = 8,
    parameter type T     = logic
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  T                       wr_data_i [N],
    input  logic [$clog2(DEPTH):0] wr_cnt_i,
    input  logic                   rd_i,
    output T                       rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] count_d_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign count_d = count_q + wr_cnt_i - CNT_W'(rd_i);

    // NOTE: state registers use <= so every flop samples pre-edge values, independent of block order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(wr_cnt_i);
            rd_ptr_q <= rd_ptr_q + PTR_W'(rd_i);
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are unreachable once count is 0.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int k = 0; k < N; k++) begin
                if (CNT_W'(k) < wr_cnt_i) begin
                    mem_q[wr_ptr_q + PTR_W'(k)] <= wr_data_i[k];
                end
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign count_d_o = count_d;

endmodule

// File: rtl/te_block_serializer.sv
// Packs up to N retired trace blocks per cycle into a FIFO and streams them one per cycle.
// Optional TE_SERIALIZER_STATS_EN adds drop_cnt_o and max_occ_o.
module te_block_serializer
    import mure_pkg::*;
#(
    parameter int N         = 2,
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    te_block_serializer_if.slave   bus
`ifdef TE_SERIALIZER_STATS_EN
    ,
    output logic [31:0]            drop_cnt_o,
    output logic [$clog2(DEPTH):0] max_occ_o
`endif
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    te_block_t        lane_blk [N];
    te_block_t        comp_blk [N];
    te_block_t        head_blk;
    logic [CNT_W-1:0] n_valid;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] free_next;
    logic             out_valid;
    logic             pop;
    logic             almost_full_d;
    logic             almost_full_q;
    logic             overflow_q;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            lane_blk[i].iretire   = bus.iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN];
            lane_blk[i].ilastsize = bus.ilastsize_i[i];
            lane_blk[i].itype     = bus.itype_i[i*ITYPE_LEN +: ITYPE_LEN];
            lane_blk[i].cause     = bus.cause_i[i*CAUSE_LEN +: CAUSE_LEN];
            lane_blk[i].tval      = bus.tval_i[i*XLEN +: XLEN];
            lane_blk[i].priv      = bus.priv_i[i*PRIV_LEN +: PRIV_LEN];
            lane_blk[i].iaddr     = bus.iaddr_i[i*XLEN +: XLEN];
        end
    end

    // Each valid lane lands in the slot given by the number of older valid lanes.
    always_comb begin
        int unsigned rank;
        // NOTE: every output gets a default first so no path through this block infers a latch.
        rank = 0;
        for (int k = 0; k < N; k++) begin
            comp_blk[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.valid_i[i]) begin
                for (int k = 0; k < N; k++) begin
                    if (rank == k) begin
                        comp_blk[k] = lane_blk[i];
                    end
                end
                rank = rank + 1;
            end
        end
        n_valid = CNT_W'(rank);
    end

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & bus.ready_i;
    assign free      = CNT_W'(DEPTH) - fifo_count + CNT_W'(pop);
    assign accepted  = (n_valid > free) ? free : n_valid;

    te_mw_fifo #(
        .N     (N),
        .DEPTH (DEPTH),
        .T     (te_block_t)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_data_i (comp_blk),
        .wr_cnt_i  (accepted),
        .rd_i      (pop),
        .rd_data_o (head_blk),
        .count_o   (fifo_count),
        .count_d_o (count_d)
    );

    assign free_next     = CNT_W'(DEPTH) - count_d;
    assign almost_full_d = 32'(free_next) < 32'(N + AF_MARGIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            almost_full_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            almost_full_q <= almost_full_d;
            overflow_q    <= (n_valid > free);
        end
    end

    // Head fields are forced to zero while nothing is valid.
    assign bus.valid_o       = out_valid;
    assign bus.iretire_o     = out_valid ? head_blk.iretire   : '0;
    assign bus.ilastsize_o   = out_valid ? head_blk.ilastsize : 1'b0;
    assign bus.itype_o       = out_valid ? head_blk.itype     : '0;
    assign bus.cause_o       = out_valid ? head_blk.cause     : '0;
    assign bus.tval_o        = out_valid ? head_blk.tval      : '0;
    assign bus.priv_o        = out_valid ? head_blk.priv      : '0;
    assign bus.iaddr_o       = out_valid ? head_blk.iaddr     : '0;
    assign bus.almost_full_o = almost_full_q;
    assign bus.overflow_o    = overflow_q;
    assign bus.count_o       = fifo_count;

`ifdef TE_SERIALIZER_STATS_EN
    logic [31:0]      drop_cnt_q;
    logic [31:0]      drop_cnt_d;
    logic [32:0]      drop_sum;
    logic [CNT_W-1:0] max_occ_q;

    always_comb begin
        drop_sum   = {1'b0, drop_cnt_q} + 33'(n_valid - accepted);
        drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
            max_occ_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            max_occ_q  <= (count_d > max_occ_q) ? count_d : max_occ_q;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
    assign max_occ_o  = max_occ_q;
`endif

endmodule

// File: tb/tb_te_block_serializer.sv
// Directed bench for te_block_serializer (N=2, DEPTH=8, AF_MARGIN=2); stats checks follow TE_SERIALIZER_STATS_EN.
module tb_te_block_serializer;
    import mure_pkg::*;

    localparam int N         = 2;
    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    te_block_serializer_if #(.N(N), .DEPTH(DEPTH)) bus ();

`ifdef TE_SERIALIZER_STATS_EN
    logic [31:0] drop_cnt;
    logic [3:0]  max_occ;
`endif

    te_block_serializer #(
        .N         (N),
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef TE_SERIALIZER_STATS_EN
        ,
        .drop_cnt_o (drop_cnt),
        .max_occ_o  (max_occ)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ret_of(input logic [31:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    task automatic drive(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        bus.valid_i     = v;
        bus.iaddr_i     = {a1, a0};
        bus.tval_i      = {~a1, ~a0};
        bus.iretire_i   = {ret_of(a1), ret_of(a0)};
        bus.ilastsize_i = {a1[0], a0[0]};
        bus.itype_i     = {a1[3:0], a0[3:0]};
        bus.cause_i     = {a1[8:4], a0[8:4]};
        bus.priv_i      = {a1[1:0], a0[1:0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ready_i = 1'b1;
        drive(2'b11, 32'h55, 32'h66);
        tick();
        tick();
        rst = 1'b0;
        bus.ready_i = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_o); end
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.count_o); end
        checks++; if (bus.almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", bus.almost_full_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", bus.overflow_o); end
        checks++; if (bus.iaddr_o !== 32'h0) begin errors++; $display("FAIL reset_iaddr_mask got %h exp 0", bus.iaddr_o); end
        tick();
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL reset_inputs_ignored got %0d exp 0", bus.count_o); end
    endtask

    task automatic test_pair();
        bus.ready_i = 1'b1;
        drive(2'b11, 32'h100, 32'h200);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL pair_valid got %b exp 1", bus.valid_o); end
        checks++; if (bus.iaddr_o !== 32'h100) begin errors++; $display("FAIL pair_iaddr0 got %h exp 100", bus.iaddr_o); end
        checks++; if (bus.iretire_o !== 8'h3C) begin errors++; $display("FAIL pair_iretire0 got %h exp 3c", bus.iretire_o); end
        checks++; if (bus.tval_o !== ~32'h100) begin errors++; $display("FAIL pair_tval0 got %h exp %h", bus.tval_o, ~32'h100); end
        checks++; if (bus.count_o !== 4'd2) begin errors++; $display("FAIL pair_count2 got %0d exp 2", bus.count_o); end
        tick();
        checks++; if (bus.iaddr_o !== 32'h200) begin errors++; $display("FAIL pair_iaddr1 got %h exp 200", bus.iaddr_o); end
        checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL pair_count1 got %0d exp 1", bus.count_o); end
        tick();
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL pair_count0 got %0d exp 0", bus.count_o); end
        checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL pair_empty_valid got %b exp 0", bus.valid_o); end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_lane1_only();
        bus.ready_i = 1'b0;
        drive(2'b10, 32'hDEAD0, 32'h340);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.count_o !== 4'd1) begin errors++; $display("FAIL lane1_count got %0d exp 1", bus.count_o); end
        checks++; if (bus.iaddr_o !== 32'h340) begin errors++; $display("FAIL lane1_iaddr got %h exp 340", bus.iaddr_o); end
        bus.ready_i = 1'b1;
        tick();
        checks++; if (bus.valid_o !== 1'b0 || bus.count_o !== 4'd0) begin
            errors++; $display("FAIL lane1_no_lane0 got valid %b count %0d exp 0 0", bus.valid_o, bus.count_o);
        end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_fill_overflow();
        bus.ready_i = 1'b0;
        for (int p = 0; p < 4; p++) begin
            drive(2'b11, 32'h1000 + 32'(2*p), 32'h1001 + 32'(2*p));
            tick();
            checks++; if (bus.count_o !== 4'(2*(p+1))) begin errors++; $display("FAIL fill_count p%0d got %0d exp %0d", p, bus.count_o, 2*(p+1)); end
            checks++; if (bus.almost_full_o !== (p >= 2)) begin errors++; $display("FAIL fill_af p%0d got %b exp %b", p, bus.almost_full_o, p >= 2); end
            checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fill_ovf p%0d got %b exp 0", p, bus.overflow_o); end
            checks++; if (bus.iaddr_o !== 32'h1000) begin errors++; $display("FAIL fill_hold p%0d got %h exp 1000", p, bus.iaddr_o); end
        end
        drive(2'b11, 32'h9000, 32'h9001);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL over_count got %0d exp 8", bus.count_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL over_pulse got %b exp 1", bus.overflow_o); end
        checks++; if (bus.iaddr_o !== 32'h1000) begin errors++; $display("FAIL over_hold got %h exp 1000", bus.iaddr_o); end
        tick();
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL over_pulse_end got %b exp 0", bus.overflow_o); end
        checks++; if (bus.count_o !== 4'd8 || bus.almost_full_o !== 1'b1) begin
            errors++; $display("FAIL over_state got count %0d af %b exp 8 1", bus.count_o, bus.almost_full_o);
        end
        checks++; if (bus.iaddr_o !== 32'h1000) begin errors++; $display("FAIL over_hold2 got %h exp 1000", bus.iaddr_o); end
`ifdef TE_SERIALIZER_STATS_EN
        checks++; if (drop_cnt !== 32'd2) begin errors++; $display("FAIL stats_drop2 got %0d exp 2", drop_cnt); end
        checks++; if (max_occ !== 4'd8) begin errors++; $display("FAIL stats_max_occ got %0d exp 8", max_occ); end
`endif
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_addr [8];
        for (int i = 0; i < 7; i++) exp_addr[i] = 32'h1001 + 32'(i);
        exp_addr[7] = 32'h2000;
        bus.ready_i = 1'b1;
        drive(2'b11, 32'h2000, 32'h2001);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.count_o !== 4'd8) begin errors++; $display("FAIL fullpop_count got %0d exp 8", bus.count_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL fullpop_ovf got %b exp 1", bus.overflow_o); end
`ifdef TE_SERIALIZER_STATS_EN
        checks++; if (drop_cnt !== 32'd3) begin errors++; $display("FAIL stats_drop3 got %0d exp 3", drop_cnt); end
`endif
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.valid_o !== 1'b1 || bus.iaddr_o !== exp_addr[i]) begin
                errors++; $display("FAIL fullpop_drain%0d got valid %b iaddr %h exp 1 %h", i, bus.valid_o, bus.iaddr_o, exp_addr[i]);
            end
            tick();
        end
        checks++; if (bus.count_o !== 4'd0 || bus.valid_o !== 1'b0) begin
            errors++; $display("FAIL fullpop_empty got count %0d valid %b exp 0 0", bus.count_o, bus.valid_o);
        end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL fullpop_ovf_end got %b exp 0", bus.overflow_o); end
        bus.ready_i = 1'b0;
    endtask

    task automatic test_stream_wrap();
        logic [31:0] exp_q [$];
        logic [1:0]  pat [8];
        int          issued;
        logic        prev_hold;
        logic [31:0] prev_addr;
        pat = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        issued = 0;
        prev_hold = 1'b0;
        prev_addr = '0;
        for (int cyc = 0; cyc < 200 && (issued < 20 || exp_q.size() != 0); cyc++) begin
            logic        rdy;
            logic [1:0]  v;
            logic [31:0] a0;
            logic [31:0] a1;
            if (exp_q.size() != 0) begin
                checks++; if (bus.valid_o !== 1'b1 || bus.iaddr_o !== exp_q[0]) begin
                    errors++; $display("FAIL stream_head c%0d got valid %b iaddr %h exp 1 %h", cyc, bus.valid_o, bus.iaddr_o, exp_q[0]);
                end
            end else begin
                checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL stream_idle c%0d got %b exp 0", cyc, bus.valid_o); end
            end
            if (prev_hold) begin
                checks++; if (bus.iaddr_o !== prev_addr) begin errors++; $display("FAIL stream_hold c%0d got %h exp %h", cyc, bus.iaddr_o, prev_addr); end
            end
            checks++; if (bus.count_o !== 4'(exp_q.size())) begin errors++; $display("FAIL stream_count c%0d got %0d exp %0d", cyc, bus.count_o, exp_q.size()); end
            checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL stream_ovf c%0d got %b exp 0", cyc, bus.overflow_o); end

            rdy = (cyc % 2 == 0);
            prev_hold = (exp_q.size() != 0) && !rdy;
            prev_addr = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
            if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());

            v  = (issued < 20) ? pat[cyc % 8] : 2'b00;
            a0 = 32'h3000 + 32'(issued);
            a1 = a0 + 32'(v[0]);
            if (v[0]) begin exp_q.push_back(a0); issued++; end
            if (v[1]) begin exp_q.push_back(a1); issued++; end
            bus.ready_i = rdy;
            drive(v, a0, a1);
            tick();
        end
        drive(2'b00, 32'h0, 32'h0);
        bus.ready_i = 1'b0;
        checks++; if (exp_q.size() != 0 || issued != 20) begin
            errors++; $display("FAIL stream_timeout got left %0d issued %0d exp 0 20", exp_q.size(), issued);
        end
    endtask

    task automatic test_reset_mid();
        bus.ready_i = 1'b0;
        drive(2'b11, 32'h4000, 32'h4001);
        tick();
        drive(2'b11, 32'h4002, 32'h4003);
        tick();
        drive(2'b01, 32'h4004, 32'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.count_o !== 4'd5) begin errors++; $display("FAIL rstmid_pre_count got %0d exp 5", bus.count_o); end
        rst = 1'b1;
        drive(2'b11, 32'h5000, 32'h5001);
        tick();
        rst = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.valid_o !== 1'b0 || bus.count_o !== 4'd0) begin
            errors++; $display("FAIL rstmid_clear got valid %b count %0d exp 0 0", bus.valid_o, bus.count_o);
        end
        checks++; if (bus.almost_full_o !== 1'b0) begin errors++; $display("FAIL rstmid_af got %b exp 0", bus.almost_full_o); end
`ifdef TE_SERIALIZER_STATS_EN
        checks++; if (drop_cnt !== 32'd0 || max_occ !== 4'd0) begin
            errors++; $display("FAIL rstmid_stats got drop %0d max %0d exp 0 0", drop_cnt, max_occ);
        end
`endif
        bus.ready_i = 1'b1;
        drive(2'b01, 32'h777, 32'h0);
        tick();
        drive(2'b00, 32'h0, 32'h0);
        checks++; if (bus.valid_o !== 1'b1 || bus.iaddr_o !== 32'h777 || bus.count_o !== 4'd1) begin
            errors++; $display("FAIL rstmid_push got valid %b iaddr %h count %0d exp 1 777 1", bus.valid_o, bus.iaddr_o, bus.count_o);
        end
        tick();
        checks++; if (bus.count_o !== 4'd0) begin errors++; $display("FAIL rstmid_drain got %0d exp 0", bus.count_o); end
        bus.ready_i = 1'b0;
    endtask

    initial begin
        bus.ready_i = 1'b0;
        drive(2'b00, 32'h0, 32'h0);
        test_reset();
        test_pair();
        test_lane1_only();
        test_fill_overflow();
        test_full_pop();
        test_stream_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
